// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - highway/farm-road light sequencer with car-sensor debounce; optional TRAFFIC_PED_WALK_EN
module traffic_light_ctrl #(
    parameter int CAR_SYNC_STAGES = 2,
    parameter int CAR_DEB         = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c,
    input  logic       ts,
    input  logic       tl,
`ifdef TRAFFIC_PED_WALK_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic       st,
    output logic [1:0] hl,
    output logic [1:0] fl,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        HG = 2'b00,
        HY = 2'b01,
        FG = 2'b10,
        FY = 2'b11
    } state_t;

    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b10;
    localparam int         CW          = (CAR_DEB < 2) ? 1 : $clog2(CAR_DEB + 1);

    state_t                   cur_state;
    state_t                   next_state;
    logic                     st_next;
    logic [1:0]               hl_next;
    logic [1:0]               fl_next;
    logic                     armed;
    logic                     adv_ok;
    logic [CAR_SYNC_STAGES-1:0] sync;
    logic                     car_s;
    logic [CW-1:0]            deb_cnt;
    logic                     car_q;
    logic                     ped_pend;

    assign car_s = sync[CAR_SYNC_STAGES-1];
    assign state = cur_state;

    // Sensor synchroniser followed by a consecutive-sample debounce on car_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= '0;
            deb_cnt <= '0;
            car_q   <= 1'b0;
        end else begin
            sync <= {sync[CAR_SYNC_STAGES-2:0], c};
            if (car_s == car_q) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CW'(CAR_DEB - 1)) begin
                deb_cnt <= '0;
                car_q   <= ~car_q;
            end else begin
                deb_cnt <= deb_cnt + CW'(1);
            end
        end
    end

`ifdef TRAFFIC_PED_WALK_EN
    logic enter_fy;
    logic ped_pend_next;

    assign enter_fy      = st_next && (next_state == FY);
    assign ped_pend_next = ped_req | (ped_pend & ~enter_fy);

    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pend <= 1'b0;
            walk     <= 1'b0;
        end else begin
            ped_pend <= ped_pend_next;
            walk     <= (next_state == FG) && ped_pend_next && !enter_fy;
        end
    end
`else
    assign ped_pend = 1'b0;
`endif

    // Timeouts seen in the st cycle or the one before arming belong to the previous phase.
    assign adv_ok = armed & ~st;

    always_comb begin
        next_state = cur_state;
        st_next    = 1'b0;
        hl_next    = LAMP_GREEN;
        fl_next    = LAMP_RED;
        case (cur_state)
            HG: begin
                if ((car_q | ped_pend) && tl && adv_ok) begin
                    next_state = HY;
                    st_next    = 1'b1;
                end
            end
            HY: begin
                if (ts && adv_ok) begin
                    next_state = FG;
                    st_next    = 1'b1;
                end
            end
            FG: begin
                if (((!car_q && !ped_pend) || tl) && adv_ok) begin
                    next_state = FY;
                    st_next    = 1'b1;
                end
            end
            FY: begin
                if (ts && adv_ok) begin
                    next_state = HG;
                    st_next    = 1'b1;
                end
            end
            default: begin
                next_state = HG;
                st_next    = 1'b1;
            end
        endcase

        case (next_state)
            HG:      begin hl_next = LAMP_GREEN;  fl_next = LAMP_RED;    end
            HY:      begin hl_next = LAMP_YELLOW; fl_next = LAMP_RED;    end
            FG:      begin hl_next = LAMP_RED;    fl_next = LAMP_GREEN;  end
            FY:      begin hl_next = LAMP_RED;    fl_next = LAMP_YELLOW; end
            default: begin hl_next = LAMP_GREEN;  fl_next = LAMP_RED;    end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= HG;
            hl        <= LAMP_GREEN;
            fl        <= LAMP_RED;
            st        <= 1'b1;
            armed     <= 1'b0;
        end else begin
            cur_state <= next_state;
            hl        <= hl_next;
            fl        <= fl_next;
            st        <= st_next;
            armed     <= ~st_next;
        end
    end

endmodule
